// File: rtl/cbg_fifo_pkg.sv
// Shared definitions for the CBG FIFO data path: default sizes, the storage
// index-width helper and the output-queue occupancy encoding.
package cbg_fifo_pkg;

    localparam int unsigned CBG_D_W = 32;
    localparam int unsigned CBG_F_D = 8;
    localparam int unsigned CBG_A_W = 32;

    // Index width for a depth-entry array; never narrower than one bit.
    function automatic int unsigned cbg_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/cbg_out_skid.sv
// Two-entry output queue between the storage read port and the consuming PE.
// Head always holds the oldest word; a word pushed into a full queue is dropped.
module cbg_out_skid
    import cbg_fifo_pkg::*;
#(
    parameter int unsigned D_W = CBG_D_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push,
    input  logic [D_W-1:0] push_data,
    input  logic           out_ready,
    output logic [D_W-1:0] out_data,
    output logic           out_valid,
    output logic           pop,
    output logic [1:0]     occ,
    output logic           overflow
);

    occ_e           occ_q;
    logic [D_W-1:0] head_q;
    logic [D_W-1:0] tail_q;
    logic           overflow_q;

    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_data  = head_q;
    assign pop       = out_valid & out_ready;
    assign occ       = occ_q;
    assign overflow  = overflow_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= OCC_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            occ_q      <= OCC_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    unique case (occ_q)
                        OCC_EMPTY: begin
                            head_q <= push_data;
                            occ_q  <= OCC_ONE;
                        end
                        OCC_ONE: begin
                            tail_q <= push_data;
                            occ_q  <= OCC_FULL;
                        end
                        default: overflow_q <= 1'b1;
                    endcase
                end
                2'b01: begin
                    unique case (occ_q)
                        OCC_FULL: begin
                            head_q <= tail_q;
                            occ_q  <= OCC_ONE;
                        end
                        default: occ_q <= OCC_EMPTY;
                    endcase
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy holds, order is kept.
                    unique case (occ_q)
                        OCC_FULL: begin
                            head_q <= tail_q;
                            tail_q <= push_data;
                        end
                        default: head_q <= push_data;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cbg_fifo_datapath.sv
// CBG FIFO data half: storage array written/read by the address controller,
// a registered read port feeding the output queue, and read-credit generation.
module cbg_fifo_datapath
    import cbg_fifo_pkg::*;
#(
    parameter int unsigned D_W = CBG_D_W,
    parameter int unsigned F_D = CBG_F_D,
    parameter int unsigned A_W = CBG_A_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           flush,
    input  logic           we_n,
    input  logic           re_n,
    input  logic [A_W-1:0] wr_addr,
    input  logic [A_W-1:0] rd_addr,
    input  logic [D_W-1:0] wr_data,
    output logic           re_req,
    output logic [D_W-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           overflow
);

    localparam int unsigned IDX_W = cbg_idx_w(F_D);

    logic [D_W-1:0]   mem [F_D];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [D_W-1:0]   rdata_q;
    logic             pend;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       credit_fill;

    // The controller keeps pointers below F_D, so only the low bits index storage.
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_idx = rd_addr[IDX_W-1:0];

    if (A_W > IDX_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{wr_addr[A_W-1:IDX_W], rd_addr[A_W-1:IDX_W]};
    end

    // NOTE: the storage array has no reset; it maps onto plain RAM and every
    // word is written before the controller lets it be read.
    always_ff @(posedge clk) begin
        if (we_n && !flush) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A same-address write in this cycle lands after the edge, so the read
    // below returns the old contents (read-first).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend    <= 1'b0;
            rdata_q <= '0;
        end else if (flush) begin
            pend    <= 1'b0;
        end else begin
            pend <= re_n;
            if (re_n) begin
                rdata_q <= mem[rd_idx];
            end
        end
    end

    cbg_out_skid #(
        .D_W (D_W)
    ) u_out_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (pend),
        .push_data (rdata_q),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .pop       (pop),
        .occ       (occ),
        .overflow  (overflow)
    );

    // Credit counts the word still in flight (pend) and frees the slot being
    // popped this cycle, which is what sustains one word per cycle.
    // NOTE: every always_comb output gets a value on every path, so no latch.
    always_comb begin
        credit_fill = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
        re_req      = rst & en & ~flush & (credit_fill < 3'd2);
    end

endmodule

// File: tb/tb_cbg_fifo_datapath.sv
// Scoreboard bench for cbg_fifo_datapath: reads push expected words into a
// queue, a negedge monitor pops and compares on every accepted output.
module tb_cbg_fifo_datapath;

    localparam int unsigned D_W = 32;
    localparam int unsigned F_D = 8;
    localparam int unsigned A_W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           flush;
    logic           we_n;
    logic           re_n;
    logic [A_W-1:0] wr_addr;
    logic [A_W-1:0] rd_addr;
    logic [D_W-1:0] wr_data;
    logic           re_req;
    logic [D_W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           overflow;

    int unsigned    errors = 0;
    int unsigned    checks = 0;
    int unsigned    cyc = 0;
    int unsigned    n_deliv = 0;
    int unsigned    first_cyc = 0;
    int unsigned    last_cyc = 0;
    logic [D_W-1:0] model [F_D];
    logic [D_W-1:0] exp_q [$];

    cbg_fifo_datapath #(
        .D_W (D_W),
        .F_D (F_D),
        .A_W (A_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .we_n      (we_n),
        .re_n      (re_n),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .re_req    (re_req),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every accepted output word must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h, required no output", out_data);
            end else begin
                check("sb_data", out_data, exp_q.pop_front());
            end
            n_deliv++;
            if (n_deliv == 1) first_cyc = cyc;
            last_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int unsigned addr, input logic [D_W-1:0] data);
        we_n    = 1'b1;
        wr_addr = addr;
        wr_data = data;
        model[addr] = data;
        tick();
        we_n = 1'b0;
    endtask

    task automatic rd(input int unsigned addr);
        re_n    = 1'b1;
        rd_addr = addr;
        exp_q.push_back(model[addr]);
        tick();
        re_n = 1'b0;
    endtask

    initial begin
        int unsigned ptr;
        rst = 1'b0; en = 1'b1; flush = 1'b0; we_n = 1'b0; re_n = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; out_ready = 1'b0;
        #1;
        check("rst_re_req", re_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overflow", overflow, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) wr(i, 32'h5000_0000 + i);

        // Mid-stream reset with a full output queue.
        rd(0);
        rd(1);
        tick();
        check("full_valid", out_valid, 1);
        check("full_head", out_data, model[0]);
        #1 rst = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_re_req", re_req, 0);
        check("midrst_data", out_data, 0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        #1;
        check("postrst_re_req", re_req, 1);
        tick();

        // Write then read: one-edge latency into an empty queue.
        wr(3, 32'hA5A5_0001);
        rd(3);
        check("lat_not_early", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 32'hA5A5_0001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("lat_drained", out_valid, 0);

        // Streaming driven by re_req: one word per cycle once started.
        for (int i = 0; i < 8; i++) wr(i, 32'h5000_0000 + i);
        ptr = 0;
        n_deliv = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && !(ptr == 8 && exp_q.size() == 0); c++) begin
            #1;
            if (re_req && ptr < 8) begin
                re_n    = 1'b1;
                rd_addr = ptr;
                exp_q.push_back(model[ptr]);
                ptr++;
            end else begin
                re_n = 1'b0;
            end
            tick();
        end
        re_n = 1'b0;
        check("stream_count", n_deliv, 8);
        check("stream_span", last_cyc - first_cyc, 7);

        // Backpressure: credit closes at two words, reopens on the pop cycle.
        out_ready = 1'b0;
        rd(0);
        rd(1);
        check("bp_re_req_inflight", re_req, 0);
        tick();
        check("bp_re_req_full", re_req, 0);
        check("bp_head", out_data, model[0]);
        tick();
        check("bp_head_hold", out_data, model[0]);
        out_ready = 1'b1;
        #1;
        check("bp_re_req_reopen", re_req, 1);
        tick();
        tick();
        check("bp_drained", out_valid, 0);

        // Read-first collision on one address.
        wr(5, 32'h0000_0011);
        we_n = 1'b1; wr_addr = 5; wr_data = 32'h0000_0022;
        re_n = 1'b1; rd_addr = 5;
        exp_q.push_back(model[5]);
        model[5] = 32'h0000_0022;
        tick();
        we_n = 1'b0;
        re_n = 1'b0;
        rd(5);
        tick();
        tick();
        check("coll_drained", out_valid, 0);

        // Forced read into a full queue, then flush.
        out_ready = 1'b0;
        rd(0);
        rd(1);
        tick();
        re_n = 1'b1;
        rd_addr = 2;
        tick();
        re_n = 1'b0;
        tick();
        check("ovf_set", overflow, 1);
        check("ovf_valid", out_valid, 1);
        check("ovf_head", out_data, model[0]);
        check("ovf_re_req", re_req, 0);
        en = 1'b0;
        out_ready = 1'b1;
        #1;
        check("en0_re_req", re_req, 0);
        tick();
        out_ready = 1'b0;
        en = 1'b1;
        check("ovf_dropped_word", out_data, model[1]);
        check("ovf_sticky", overflow, 1);
        flush = 1'b1;
        #1;
        check("flush_re_req", re_req, 0);
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("flush_overflow", overflow, 0);
        check("flush_valid", out_valid, 0);
        check("flush_data", out_data, 0);
        out_ready = 1'b1;
        rd(5);
        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);
        check("end_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cbg_fifo_datapath.md
Name: cbg_fifo_datapath

Overview:
- Data half of the CBG FIFO, directly downstream of the FIFO address/count controller.
- Holds the F_D-entry storage array. Writes wr_data at wr_addr on we_n. Reads rd_addr on re_n into a 2-entry output queue.
- Presents the output queue as a valid/ready stream to the consuming PE.
- Drives re_req back to the controller's re input as read credit.

Parameters:
- D_W, 32, data word width.
- F_D, 8, FIFO depth in words; must equal the controller's depth.
- A_W, 32, address width as driven by the controller; only the low clog2(F_D) bits index storage.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  block enable, shared with the controller.
- flush  in  1  synchronous clear, shared with the controller.
- we_n  in  1  qualified write strobe from the controller.
- re_n  in  1  qualified read strobe from the controller.
- wr_addr  in  A_W  write pointer from the controller.
- rd_addr  in  A_W  read pointer from the controller.
- wr_data  in  D_W  write data from the upstream producer.
- re_req  out  1  read request to the controller's re input.
- out_data  out  D_W  head of the output queue.
- out_valid  out  1  output queue non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- overflow  out  1  sticky: a read word arrived with no queue space.

Behaviour:
- Reset (rst=0, async): out_valid=0, out_data=0, overflow=0, queue occupancy=0, pend=0.
  - re_req=0 while in reset.
  - Storage array is not reset.
- flush=1 (sync, rst high): same clear as reset, effective next edge. Storage contents retained. Flush overrides all same-cycle events.
- Write: on posedge with we_n=1, mem[wr_addr] <= wr_data.
  - we_n is already en-qualified; this block does not re-check full.
- Read launch: on posedge with re_n=1, mem[rd_addr] is captured into rdata_q; pend <= 1. Otherwise pend <= 0.
  - Read-first semantics: if we_n and re_n hit the same address in one cycle, the captured word is the old contents.
- Read latency: re_n at edge N. The word is in the output queue and visible on out_data at edge N+1, provided the queue was empty.
- Output queue: 2 entries, head/tail, occ in {0,1,2}.
  - pop = out_valid & out_ready.
  - push = pend (the word in rdata_q).
  - push and pop in the same cycle: occ unchanged, order preserved.
  - Push into an empty queue lands directly in head.
- out_valid = (occ != 0). out_data = head entry.
  - Both are stable while out_valid=1 and out_ready=0.
- Credit:
  - re_req = en & ~flush & ((occ + pend - pop) < 2).
  - Combinational from out_ready; gives one word per cycle sustained.
- Overflow:
  - push with occ=2 and no pop: the word is dropped and overflow <= 1.
  - Can only happen on a controller-forced read (almost-full eviction).
  - overflow is cleared only by rst or flush.
- en=0:
  - re_req=0; writes and reads follow we_n/re_n, which are already gated.
  - The output queue still drains on out_ready.
- Arithmetic:
  - Address index = addr[clog2(F_D)-1:0]; controller guarantees addr < F_D.
  - occ is 2 bits with saturating logic as above.

Decomposition:
- Shared header (existing parameter define file): D_W, F_D, A_W defaults and a CLOG2 index-width macro.
- One natural sub-module: cbg_out_skid, the 2-entry output queue with push/pop/occ/overflow.
- Storage array and credit logic stay in the top.

Test Plan:
1. Reset: hold rst=0 mid-stream with occ=2 -> out_valid=0, overflow=0, re_req=0 immediately. After release with en=1, re_req=1.
2. Write then read: write 0xA5A5_0001 at addr 3; re_n at addr 3 at edge N -> out_data=0xA5A5_0001, out_valid=1 at edge N+1.
3. Streaming: out_ready=1, controller driven by re_req, 8 words 0..7 prewritten -> one word per cycle, order 0..7, no bubbles after first.
4. Backpressure: out_ready=0 after 2 reads -> re_req drops to 0, out_data holds word 0. Then out_ready=1 -> words 0,1 delivered, re_req reasserts the same cycle.
5. Read-first collision: mem[5]=0x11, we_n and re_n both at addr 5 with wr_data=0x22 -> captured 0x11. Next read of addr 5 -> 0x22.
6. Overflow/flush: occ=2, out_ready=0, force re_n=1 -> overflow=1, occ stays 2, queue contents unchanged. Then flush=1 -> overflow=0, out_valid=0, mem[5] still 0x22.
